// File: rtl/fmcrop_pkg.sv
// rtl/fmcrop_pkg.sv - shared config address map and decode for the feature-map cropping block
package fmcrop_pkg;

  localparam logic [4:0] ADDR_XON  = 5'd0;
  localparam logic [4:0] ADDR_XOFF = 5'd4;
  localparam logic [4:0] ADDR_XEND = 5'd8;
  localparam logic [4:0] ADDR_YON  = 5'd12;
  localparam logic [4:0] ADDR_YOFF = 5'd16;
  localparam logic [4:0] ADDR_YEND = 5'd20;

  typedef enum logic [2:0] {
    REG_XON,
    REG_XOFF,
    REG_XEND,
    REG_YON,
    REG_YOFF,
    REG_YEND,
    REG_NONE
  } cfg_reg_e;

  function automatic cfg_reg_e cfg_decode(input logic [4:0] addr);
    case (addr)
      ADDR_XON:  return REG_XON;
      ADDR_XOFF: return REG_XOFF;
      ADDR_XEND: return REG_XEND;
      ADDR_YON:  return REG_YON;
      ADDR_YOFF: return REG_YOFF;
      ADDR_YEND: return REG_YEND;
      default:   return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fm_pos_counter.sv
// rtl/fm_pos_counter.sv - nested beat/column/row position counter with window test
module fm_pos_counter
  import fmcrop_pkg::*;
#(
  parameter int XCOUNTER_BITS = 8,
  parameter int YCOUNTER_BITS = 8,
  parameter int SF            = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [XCOUNTER_BITS-1:0] x_on,
  input  logic [XCOUNTER_BITS-1:0] x_off,
  input  logic [XCOUNTER_BITS-1:0] x_end,
  input  logic [YCOUNTER_BITS-1:0] y_on,
  input  logic [YCOUNTER_BITS-1:0] y_off,
  input  logic [YCOUNTER_BITS-1:0] y_end,
  output logic                     fwd,
  output logic                     frame_end
);

  localparam int SB = (SF > 1) ? $clog2(SF) : 1;
  localparam logic [SB-1:0] S_LAST = SB'(SF - 1);

  logic [SB-1:0]            s;
  logic [XCOUNTER_BITS-1:0] x;
  logic [YCOUNTER_BITS-1:0] y;

  // S counts down the beats of one pixel; X/Y step once per completed pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= S_LAST;
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (s != '0) begin
        s <= s - 1'b1;
      end else begin
        s <= S_LAST;
        if (x == x_end) begin
          x <= '0;
          y <= (y == y_end) ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  assign fwd       = (x >= x_on) && (x < x_off) && (y >= y_on) && (y < y_off);
  assign frame_end = (s == '0) && (x == x_end) && (y == y_end);

endmodule

// File: rtl/fmcropping.sv
// rtl/fmcropping.sv - feature-map cropping: forwards only stream beats inside the configured window
module fmcropping
  import fmcrop_pkg::*;
#(
  parameter int XCOUNTER_BITS = 8,
  parameter int YCOUNTER_BITS = 8,
  parameter int NUM_CHANNELS  = 16,
  parameter int SIMD          = 4,
  parameter int ELEM_BITS     = 8,
  parameter int INIT_XON      = 1,
  parameter int INIT_XOFF     = 5,
  parameter int INIT_XEND     = 5,
  parameter int INIT_YON      = 1,
  parameter int INIT_YOFF     = 5,
  parameter int INIT_YEND     = 5,
  localparam int STREAM_BITS  = 8 * ((SIMD * ELEM_BITS + 7) / 8)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic                   we,
  input  logic [4:0]             wa,
  input  logic [31:0]            wd,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tvalid,
  input  logic [STREAM_BITS-1:0] s_axis_tdata,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [STREAM_BITS-1:0] m_axis_tdata
);

  localparam int SF = NUM_CHANNELS / SIMD;

  typedef logic [XCOUNTER_BITS-1:0] xcount_t;
  typedef logic [YCOUNTER_BITS-1:0] ycount_t;
  typedef struct packed {
    logic                   vld;
    logic [STREAM_BITS-1:0] dat;
  } buf_t;

  if (NUM_CHANNELS % SIMD != 0) begin : g_simd_chk
    $fatal(1, "fmcropping: NUM_CHANNELS must be a multiple of SIMD");
  end
  if (INIT_XEND >= (1 << XCOUNTER_BITS) || INIT_XON >= (1 << XCOUNTER_BITS) ||
      INIT_XOFF >= (1 << XCOUNTER_BITS)) begin : g_xw_chk
    $fatal(1, "fmcropping: XCOUNTER_BITS too small for initial X configuration");
  end
  if (INIT_YEND >= (1 << YCOUNTER_BITS) || INIT_YON >= (1 << YCOUNTER_BITS) ||
      INIT_YOFF >= (1 << YCOUNTER_BITS)) begin : g_yw_chk
    $fatal(1, "fmcropping: YCOUNTER_BITS too small for initial Y configuration");
  end
  if (INIT_XOFF <= INIT_XON || INIT_YOFF <= INIT_YON) begin : g_empty_warn
    $warning("fmcropping: initial crop window is empty, every beat will be dropped");
  end

  // Window registers survive ap_rst; only their power-up value is defined
  xcount_t x_on  = xcount_t'(INIT_XON);
  xcount_t x_off = xcount_t'(INIT_XOFF);
  xcount_t x_end = xcount_t'(INIT_XEND);
  ycount_t y_on  = ycount_t'(INIT_YON);
  ycount_t y_off = ycount_t'(INIT_YOFF);
  ycount_t y_end = ycount_t'(INIT_YEND);

  cfg_reg_e wsel;
  logic     unused_wd;
  assign wsel      = cfg_decode(wa);
  assign unused_wd = ^wd;

  always_ff @(posedge ap_clk) begin
    if (we) begin
      case (wsel)
        REG_XON:  x_on  <= wd[XCOUNTER_BITS-1:0];
        REG_XOFF: x_off <= wd[XCOUNTER_BITS-1:0];
        REG_XEND: x_end <= wd[XCOUNTER_BITS-1:0];
        REG_YON:  y_on  <= wd[YCOUNTER_BITS-1:0];
        REG_YOFF: y_off <= wd[YCOUNTER_BITS-1:0];
        REG_YEND: y_end <= wd[YCOUNTER_BITS-1:0];
        default:  ;
      endcase
    end
  end

  buf_t skid_a;
  buf_t out_b;
  logic acc;
  logic fwd;
  logic frame_end;
  logic in_frame;

  assign s_axis_tready = !skid_a.vld;
  assign acc           = s_axis_tvalid && s_axis_tready;
  assign m_axis_tvalid = out_b.vld;
  assign m_axis_tdata  = out_b.dat;

  fm_pos_counter #(
    .XCOUNTER_BITS(XCOUNTER_BITS),
    .YCOUNTER_BITS(YCOUNTER_BITS),
    .SF           (SF)
  ) u_pos (
    .clk      (ap_clk),
    .rst      (ap_rst),
    .en       (acc),
    .x_on     (x_on),
    .x_off    (x_off),
    .x_end    (x_end),
    .y_on     (y_on),
    .y_off    (y_off),
    .y_end    (y_end),
    .fwd      (fwd),
    .frame_end(frame_end)
  );

  // B is the output register; A only fills when B is held by back-pressure
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      skid_a.vld <= 1'b0;
      out_b.vld  <= 1'b0;
    end else if (!out_b.vld || m_axis_tready) begin
      if (skid_a.vld) begin
        out_b      <= skid_a;
        skid_a.vld <= 1'b0;
      end else if (acc && fwd) begin
        out_b <= '{vld: 1'b1, dat: s_axis_tdata};
      end else begin
        out_b.vld <= 1'b0;
      end
    end else if (acc && fwd) begin
      skid_a <= '{vld: 1'b1, dat: s_axis_tdata};
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      in_frame <= 1'b0;
    end else if (acc) begin
      in_frame <= !frame_end;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst && we) begin
      assert (wsel != REG_NONE)
        else $warning("fmcropping: write to unmapped config address %0d ignored", wa);
      assert (!in_frame)
        else $warning("fmcropping: config write while a frame is in progress");
    end
  end

endmodule

// File: tb/tb_fmcropping.sv
// tb/tb_fmcropping.sv - self-checking bench for fmcropping (SF=1 6x6 and SF=4 3x3 instances)
module tb_fmcropping;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        s_vld = 1'b0;
  logic [31:0] s_data = '0;
  logic        m_rdy = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;

  logic        a_srdy, a_mvld, b_srdy, b_mvld;
  logic [31:0] a_mdata, b_mdata;
  logic        s_rdy, m_vld;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  fmcropping #(.NUM_CHANNELS(4), .SIMD(4)) dut_a (
    .ap_clk(clk), .ap_rst(rst), .we(we && !sel), .wa(wa), .wd(wd),
    .s_axis_tready(a_srdy), .s_axis_tvalid(s_vld && !sel), .s_axis_tdata(s_data),
    .m_axis_tready(m_rdy || sel), .m_axis_tvalid(a_mvld), .m_axis_tdata(a_mdata)
  );

  fmcropping #(.INIT_XON(1), .INIT_XOFF(2), .INIT_XEND(2),
               .INIT_YON(1), .INIT_YOFF(2), .INIT_YEND(2)) dut_b (
    .ap_clk(clk), .ap_rst(rst), .we(we && sel), .wa(wa), .wd(wd),
    .s_axis_tready(b_srdy), .s_axis_tvalid(s_vld && sel), .s_axis_tdata(s_data),
    .m_axis_tready(m_rdy || !sel), .m_axis_tvalid(b_mvld), .m_axis_tdata(b_mdata)
  );

  assign s_rdy  = sel ? b_srdy : a_srdy;
  assign m_vld  = sel ? b_mvld : a_mvld;
  assign m_data = sel ? b_mdata : a_mdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: window and geometry per instance, beat position within the frame
  int xon[2]  = '{1, 1};
  int xoff[2] = '{5, 2};
  int xend[2] = '{5, 2};
  int yon[2]  = '{1, 1};
  int yoff[2] = '{5, 2};
  int yend[2] = '{5, 2};
  int sf[2]   = '{1, 4};
  int beat_idx[2] = '{0, 0};

  logic [31:0] exp_q[$];
  logic [31:0] got[$];
  logic        last_acc = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] hold_data = '0;
  logic        rand_rdy = 1'b0;

  function automatic int frame_beats(input int d);
    return sf[d] * (xend[d] + 1) * (yend[d] + 1);
  endfunction

  function automatic bit model_fwd(input int d, input int n);
    int pix, x, y;
    pix = (n / sf[d]) % ((xend[d] + 1) * (yend[d] + 1));
    x = pix % (xend[d] + 1);
    y = pix / (xend[d] + 1);
    return (x >= xon[d]) && (x < xoff[d]) && (y >= yon[d]) && (y < yoff[d]);
  endfunction

  function automatic logic [31:0] pack(input int n);
    return {8'(4 * n + 3), 8'(4 * n + 2), 8'(4 * n + 1), 8'(4 * n)};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // Observe one clock at the falling edge, then return just after the rising edge
  task automatic cycle();
    logic [31:0] e;
    @(negedge clk);
    last_acc = 1'b0;
    if (rst) begin
      exp_q.delete();
      beat_idx[0] = 0;
      beat_idx[1] = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checkb("stall_vld", m_vld, 1'b1);
        check32("stall_hold", m_data, hold_data);
      end
      if (m_vld && m_rdy) begin
        got.push_back(m_data);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL extra_beat: got %h, required no output", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            n_bad++;
            $display("FAIL out_data: got %h, required %h", m_data, e);
          end
        end
      end
      if (s_vld && s_rdy) begin
        last_acc = 1'b1;
        if (model_fwd(int'(sel), beat_idx[sel])) exp_q.push_back(s_data);
        beat_idx[sel] = (beat_idx[sel] + 1) % frame_beats(int'(sel));
      end
      stall_prev = m_vld && !m_rdy;
      hold_data  = m_data;
    end
    @(posedge clk);
    #1;
    if (rand_rdy) m_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [31:0] d);
    int t;
    t = 0;
    s_vld = 1'b1;
    s_data = d;
    do begin
      cycle();
      t++;
    end while (!last_acc && t < 200);
    if (!last_acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got no accept in %0d cycles, required accept", t);
    end
    s_vld = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    rand_rdy = 1'b0;
    m_rdy = 1'b1;
    s_vld = 1'b0;
    while ((m_vld || exp_q.size() != 0) && t < 100) begin
      cycle();
      t++;
    end
    check32("drain_lost", 32'(exp_q.size()), 32'd0);
    checkb("drain_idle", m_vld, 1'b0);
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    wa = a;
    wd = d;
    we = 1'b1;
    cycle();
    we = 1'b0;
    case (a)
      5'd0:  xon[sel]  = int'(d[7:0]);
      5'd4:  xoff[sel] = int'(d[7:0]);
      5'd8:  xend[sel] = int'(d[7:0]);
      5'd12: yon[sel]  = int'(d[7:0]);
      5'd16: yoff[sel] = int'(d[7:0]);
      5'd20: yend[sel] = int'(d[7:0]);
      default: ;
    endcase
  endtask

  typedef struct {
    logic [31:0] din;
    logic        fwd;
  } vec_t;

  vec_t vec1[36];
  int   exp1[16] = '{7, 8, 9, 10, 13, 14, 15, 16, 19, 20, 21, 22, 25, 26, 27, 28};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_exp, k1, f, nacc, n;
    logic stalled;

    for (int i = 0; i < 36; i++) begin
      vec1[i].din = 32'(i);
      vec1[i].fwd = 1'b0;
      foreach (exp1[j]) if (exp1[j] == i) vec1[i].fwd = 1'b1;
    end

    repeat (3) cycle();
    rst = 1'b0;
    checkb("rst_a_vld", a_mvld, 1'b0);
    checkb("rst_a_rdy", a_srdy, 1'b1);
    checkb("rst_b_vld", b_mvld, 1'b0);
    checkb("rst_b_rdy", b_srdy, 1'b1);

    // 1: SF=1 6x6, full-rate stream, per-beat table check
    sel = 1'b0;
    got.delete();
    for (int i = 0; i < 36; i++) begin
      s_vld = 1'b1;
      s_data = vec1[i].din;
      cycle();
      checkb("t1_acc", last_acc, 1'b1);
      checkb("t1_vld", m_vld, vec1[i].fwd);
      if (vec1[i].fwd) check32("t1_dat", m_data, vec1[i].din);
    end
    drain();
    check32("t1_count", 32'(got.size()), 32'd16);

    // 2: SF=4 3x3, only the centre pixel's four beats
    sel = 1'b1;
    got.delete();
    for (int i = 0; i < 36; i++) begin
      s_vld = 1'b1;
      s_data = pack(i);
      cycle();
    end
    drain();
    check32("t2_count", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < got.size()) check32("t2_dat", got[k], pack(16 + k));

    // 3: random ready and gaps, two back-to-back frames
    sel = 1'b0;
    got.delete();
    rand_rdy = 1'b1;
    for (int i = 0; i < 72; i++) begin
      repeat ($urandom_range(0, 2)) cycle();
      send_beat($urandom);
    end
    drain();
    check32("t3_count", 32'(got.size()), 32'd32);

    // 4: output stalled while border beats keep flowing
    got.delete();
    n_exp = 0;
    k1 = -1;
    f = 0;
    for (int k = 0; k < 36 && f < 2; k++) begin
      if (model_fwd(0, k)) begin
        if (k1 < 0) k1 = k;
        f++;
      end
      n_exp = k + 1;
    end
    m_rdy = 1'b0;
    s_vld = 1'b1;
    nacc = 0;
    s_data = 32'd1000;
    for (int c = 0; c < 20; c++) begin
      cycle();
      checkb("t4_acc", last_acc, 1'(c < n_exp));
      if (last_acc) begin
        nacc++;
        s_data = 32'(1000 + nacc);
      end
    end
    check32("t4_accepted", 32'(nacc), 32'(n_exp));
    checkb("t4_srdy", s_rdy, 1'b0);
    checkb("t4_mvld", m_vld, 1'b1);
    check32("t4_mdata", m_data, 32'(1000 + k1));
    s_vld = 1'b0;
    m_rdy = 1'b1;
    for (int j = nacc; j < 36; j++) send_beat(32'(1000 + j));
    drain();
    check32("t4_count", 32'(got.size()), 32'd16);

    // 5: widen X window to full rows; unmapped address is ignored
    cfg_write(5'd0, 32'd0);
    cfg_write(5'd4, 32'd6);
    cfg_write(5'd3, 32'h0000_0055);
    got.delete();
    for (int i = 0; i < 36; i++) send_beat($urandom);
    drain();
    check32("t5_count", 32'(got.size()), 32'd24);
    cfg_write(5'd0, 32'd1);
    cfg_write(5'd4, 32'd5);

    // 6: reset with A and B both full, then a clean frame
    sel = 1'b1;
    m_rdy = 1'b0;
    s_vld = 1'b1;
    n = 0;
    stalled = 1'b0;
    for (int c = 0; c < 40 && !stalled; c++) begin
      s_data = pack(n);
      cycle();
      if (last_acc) n++;
      stalled = !s_rdy;
    end
    checkb("t6_stall", stalled, 1'b1);
    check32("t6_accepted", 32'(n), 32'd18);
    s_vld = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checkb("t6_rst_vld", m_vld, 1'b0);
    checkb("t6_rst_rdy", s_rdy, 1'b1);
    got.delete();
    m_rdy = 1'b1;
    for (int i = 0; i < 36; i++) send_beat(32'hA000_0000 + 32'(i));
    drain();
    check32("t6_count", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < got.size()) check32("t6_dat", got[k], 32'hA000_0000 + 32'(16 + k));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
